bar_sample_writer: RTL and testbench
====================================

Name: bar_sample_writer

Overview:
- Producer side of the bar-graph display path: captures a stream of 8-bit bar lengths into a ping-pong buffer, one entry per display column.
- The VGA bar renderer drives a 9-bit column address and reads back an 8-bit length.
- Banks swap only at the start of vertical sync, so the renderer never shows a half-written frame.

Parameters:
- DEPTH, 512, number of columns (entries) per bank
- AW, 9, address width; must satisfy 2^AW >= DEPTH
- DW, 8, sample/length width
- VS_ACTIVE_LOW, 1, vsync polarity; 1 means vsync is asserted when the input is 0

Ports:
- clk  in  1  system/pixel clock
- rst_n  in  1  asynchronous active-low reset
- s_data  in  DW  incoming bar length
- s_valid  in  1  s_data valid
- s_ready  out  1  writer can accept s_data this cycle
- clear  in  1  synchronous restart of the current fill, 1-cycle pulse
- vsync  in  1  vertical sync from the VGA sync generator
- rd_addr  in  AW  column address from the renderer
- rd_len  out  DW  length for rd_addr, registered
- frame_done  out  1  1-cycle pulse when the banks swap
- fill_level  out  AW+1  entries written into the write bank so far

Behaviour:
- Reset (async, rst_n=0):
  - State = FILL, wr_ptr=0, disp_bank=0, write bank=1.
  - s_ready=0 while rst_n is low; s_ready=1 on the first clk after release.
  - rd_len=0, frame_done=0, fill_level=0, disp_valid=0.
  - vs_q is set to the inactive vsync level.
  - RAM contents are not reset.
- Storage: two banks of DEPTH x DW. The write port goes to the write bank; the read port comes from disp_bank. Inferred as dual-port RAM.
- Read path: rd_len <= (disp_valid && rd_addr < DEPTH) ? mem[disp_bank][rd_addr] : 0.
  - Exactly 1-cycle latency.
  - rd_addr >= DEPTH returns 0.
  - Before the first swap (disp_valid=0), rd_len is always 0.
- Handshake: a beat is accepted when s_valid && s_ready.
  - Write mem[write bank][wr_ptr] = s_data, then wr_ptr++.
  - s_data is not held by this block once accepted.
- Vsync edge: vs_q registers vsync. vs_edge = transition from the inactive level to the active level (polarity per VS_ACTIVE_LOW). vs_edge is one cycle long.
- FSM:
  - FILL: s_ready=1.
    - An accept with wr_ptr==DEPTH-1 writes the last entry and moves to WAIT_VS. wr_ptr is held at DEPTH; s_ready=0 from the next cycle.
    - vs_edge in FILL is ignored: no swap and no pulse.
  - WAIT_VS: s_ready=0.
    - On vs_edge: go to SWAP.
  - SWAP (1 cycle): disp_bank toggles, disp_valid=1, frame_done=1, wr_ptr=0, next state FILL.
    - s_ready=0 during SWAP.
    - rd_len switches to the new bank for reads issued in the cycle after SWAP.
- clear: in any state, wr_ptr is set to 0 and the next state is FILL.
  - clear has priority over an accept in the same cycle: s_ready is forced to 0 that cycle, so no write occurs.
  - clear during SWAP still completes the swap (toggle, frame_done pulse), then goes to FILL with wr_ptr=0.
  - clear does not affect disp_bank or disp_valid.
- fill_level = wr_ptr; range 0..DEPTH.
- vs_edge and a final accept in the same cycle: the accept completes, the FSM enters WAIT_VS, and that edge is not used. The swap waits for the next vsync.
- Reset mid-operation returns everything to the reset values. The display blanks (rd_len=0) until the next full frame has been captured and swapped.

Test Plan:
- After reset, read rd_addr=5 -> rd_len=0 (disp_valid=0). Check s_ready=1 one cycle after rst_n rises.
- Stream 512 beats with s_data=i[7:0], s_valid held high -> fill_level reaches 512 and s_ready falls after beat 511. Assert vsync for the configured polarity -> exactly one frame_done pulse, 2 cycles after the vsync edge. Then rd_addr=5 -> rd_len=5 on the next cycle; rd_addr=300 -> 44.
- Frame 2 with s_data=255-i[7:0] -> before its swap, rd_addr=5 still returns 5. After the swap it returns 250. Also check rd_addr=600 -> 0.
- Fill 100 entries, then assert vsync -> no frame_done pulse and fill_level=100. Pulse clear together with s_valid -> fill_level=0 and no write that cycle. Refill 512 and swap -> data matches the refill values.
- Drive s_valid randomly (~50% duty) -> exactly 512 accepts per frame and no writes while s_ready=0 in WAIT_VS. vsync asserted in the same cycle as the final accept -> no swap until the next vsync edge.
- Assert rst_n=0 in WAIT_VS and release it -> rd_len=0, frame_done=0, fill_level=0, s_ready=1; a subsequent full frame plus swap displays correctly.

Source files
------------

// File: rtl/bar_sample_writer.sv
// Ping-pong column buffer feeding the bar-graph renderer: fills the hidden bank
// from a ready/valid stream and swaps banks only on the leading edge of vsync.
module bar_sample_writer #(
    parameter int DEPTH         = 512,
    parameter int AW            = 9,
    parameter int DW            = 8,
    parameter bit VS_ACTIVE_LOW = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic          clear,
    input  logic          vsync,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_len,
    output logic          frame_done,
    output logic [AW:0]   fill_level
);

    localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST_W  = (AW+1)'(DEPTH - 1);
    localparam logic        VS_IDLE = VS_ACTIVE_LOW;

    typedef enum logic [1:0] {FILL, WAIT_VS, SWAP} state_e;

    state_e        state_q;
    logic [AW:0]   wr_ptr_q;
    logic          disp_bank_q;
    logic          disp_valid_q;
    logic          vs_q;
    logic          rdy_q;
    logic          frame_done_q;
    logic [DW-1:0] rd_len_q;
    logic [DW-1:0] mem [2][DEPTH];

    logic vs_edge;
    logic accept;
    logic last_beat;
    logic rd_in_range;

    assign vs_edge     = (vsync != VS_IDLE) && (vs_q == VS_IDLE);
    // rdy_q keeps s_ready low until the first clock after reset release
    assign s_ready     = rdy_q && (state_q == FILL) && !clear;
    assign accept      = s_valid && s_ready;
    assign last_beat   = (wr_ptr_q == LAST_W);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);

    always_ff @(posedge clk) begin
        if (accept)
            mem[~disp_bank_q][wr_ptr_q[IW-1:0]] <= s_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FILL;
            wr_ptr_q     <= '0;
            disp_bank_q  <= 1'b0;
            disp_valid_q <= 1'b0;
            vs_q         <= VS_IDLE;
            rdy_q        <= 1'b0;
            frame_done_q <= 1'b0;
            rd_len_q     <= '0;
        end else begin
            vs_q         <= vsync;
            rdy_q        <= 1'b1;
            frame_done_q <= 1'b0;
            rd_len_q     <= (disp_valid_q && rd_in_range) ?
                            mem[disp_bank_q][rd_addr[IW-1:0]] : '0;

            if (accept)
                wr_ptr_q <= wr_ptr_q + 1'b1;

            case (state_q)
                FILL: begin
                    // an edge arriving while still filling is dropped on purpose
                    if (accept && last_beat)
                        state_q <= WAIT_VS;
                end
                WAIT_VS: begin
                    if (vs_edge)
                        state_q <= SWAP;
                end
                SWAP: begin
                    disp_bank_q  <= ~disp_bank_q;
                    disp_valid_q <= 1'b1;
                    frame_done_q <= 1'b1;
                    wr_ptr_q     <= '0;
                    state_q      <= FILL;
                end
                default: state_q <= FILL;
            endcase

            // clear restarts the fill but lets an in-flight swap complete
            if (clear) begin
                wr_ptr_q <= '0;
                state_q  <= FILL;
            end
        end
    end

    assign rd_len     = rd_len_q;
    assign frame_done = frame_done_q;
    assign fill_level = wr_ptr_q;

endmodule

// File: tb/tb_bar_sample_writer.sv
// Bench for bar_sample_writer: behavioural model plus a read scoreboard.
module tb_bar_sample_writer;

    localparam int   DEPTH   = 512;
    localparam int   AW      = 10;
    localparam int   DW      = 8;
    localparam logic VS_ACT  = 1'b0;
    localparam logic VS_IDLE = 1'b1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic          clear;
    logic          vsync;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_len;
    logic          frame_done;
    logic [AW:0]   fill_level;

    always #5 clk = ~clk;

    bar_sample_writer #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .VS_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .clear(clear), .vsync(vsync), .rd_addr(rd_addr), .rd_len(rd_len),
        .frame_done(frame_done), .fill_level(fill_level)
    );

    int checks = 0;
    int errors = 0;

    typedef enum {M_FILL, M_WAIT, M_SWAP} mst_t;
    mst_t       m_state;
    int         m_ptr;
    logic       m_disp, m_dvalid, m_vsq, m_rdy, m_fd;
    logic [7:0] mem_m [2][DEPTH];
    logic [7:0] sb [$];
    int         n_acc;

    function automatic void m_reset();
        m_state = M_FILL; m_ptr = 0; m_disp = 1'b0; m_dvalid = 1'b0;
        m_vsq = VS_IDLE; m_rdy = 1'b0; m_fd = 1'b0;
        sb.delete();
    endfunction

    function automatic logic [7:0] dval(input int kind, input int i);
        logic [7:0] b;
        b = 8'(i);
        case (kind)
            0: return b;
            1: return 8'(255 - int'(b));
            2: return 8'(i * 3);
            default: return b ^ 8'h5A;
        endcase
    endfunction

    // One clock: drive inputs, check s_ready, push read expectation, advance model, check outputs.
    task automatic cyc(input logic sv, input logic [7:0] d, input logic clr,
                       input logic vs, input logic [AW-1:0] a);
        logic       exp_rdy, acc, edg;
        logic [7:0] exp_rd;
        mst_t       pre;
        s_valid = sv; s_data = d; clear = clr; vsync = vs; rd_addr = a;
        #1;
        exp_rdy = m_rdy && (m_state == M_FILL) && !clr;
        checks++;
        if (s_ready !== exp_rdy) begin
            errors++;
            $display("FAIL s_ready got %0b expected %0b t=%0t", s_ready, exp_rdy, $time);
        end
        acc = sv && exp_rdy;
        edg = (vs == VS_ACT) && (m_vsq != VS_ACT);
        exp_rd = 8'h00;
        if (m_dvalid && int'(a) < DEPTH) exp_rd = mem_m[m_disp][int'(a)];
        sb.push_back(exp_rd);
        pre = m_state; m_fd = 1'b0;
        if (acc) begin
            mem_m[~m_disp][m_ptr] = d;
            m_ptr++; n_acc++;
        end
        case (pre)
            M_FILL: if (acc && m_ptr == DEPTH) m_state = M_WAIT;
            M_WAIT: if (edg) m_state = M_SWAP;
            M_SWAP: begin
                m_disp = ~m_disp; m_dvalid = 1'b1; m_fd = 1'b1;
                m_ptr = 0; m_state = M_FILL;
            end
            default: ;
        endcase
        if (clr) begin m_ptr = 0; m_state = M_FILL; end
        m_vsq = vs; m_rdy = 1'b1;
        @(posedge clk); #1;
        exp_rd = sb.pop_front();
        checks++;
        if (rd_len !== exp_rd) begin
            errors++;
            $display("FAIL rd_len addr=%0d got %0d expected %0d t=%0t", a, rd_len, exp_rd, $time);
        end
        checks++;
        if (frame_done !== m_fd) begin
            errors++;
            $display("FAIL frame_done got %0b expected %0b t=%0t", frame_done, m_fd, $time);
        end
        checks++;
        if (fill_level !== (AW+1)'(m_ptr)) begin
            errors++;
            $display("FAIL fill_level got %0d expected %0d t=%0t", fill_level, m_ptr, $time);
        end
    endtask

    task automatic stream(input int n, input int kind);
        for (int i = 0; i < n; i++) cyc(1'b1, dval(kind, i), 1'b0, VS_IDLE, '0);
    endtask

    task automatic rd(input int a);
        cyc(1'b0, 8'h00, 1'b0, VS_IDLE, AW'(a));
    endtask

    task automatic sweep();
        for (int a = 0; a < DEPTH; a++) rd(a);
    endtask

    // vsync active for 3 cycles then idle; reports pulse count and the cycle it appeared in
    task automatic swap_vs(output int pulses, output int at);
        pulses = 0; at = -1;
        for (int k = 0; k < 6; k++) begin
            cyc(1'b0, 8'h00, 1'b0, (k < 3) ? VS_ACT : VS_IDLE, '0);
            if (frame_done === 1'b1) begin pulses++; at = k; end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rd_len !== 8'h00 || frame_done !== 1'b0 || fill_level !== '0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state rd_len=%0d frame_done=%0b fill=%0d s_ready=%0b expected 0/0/0/0",
                     rd_len, frame_done, fill_level, s_ready);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_clk got %0b expected 0", s_ready);
        end
        @(posedge clk); #1;
        m_rdy = 1'b1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release got %0b expected 1", s_ready);
        end
        rd(5);
        checks++;
        if (rd_len !== 8'd0) begin
            errors++;
            $display("FAIL rd_before_swap got %0d expected 0", rd_len);
        end
    endtask

    task automatic test_frame1();
        int p, at;
        n_acc = 0;
        stream(DEPTH, 0);
        checks++;
        if (fill_level !== 11'd512 || n_acc != DEPTH) begin
            errors++;
            $display("FAIL frame1_fill got %0d accepts=%0d expected 512", fill_level, n_acc);
        end
        cyc(1'b1, 8'hEE, 1'b0, VS_IDLE, '0);
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_full got %0b expected 0", s_ready);
        end
        swap_vs(p, at);
        checks++;
        if (p != 1 || at != 1) begin
            errors++;
            $display("FAIL frame1_pulse count=%0d at=%0d expected 1 at 1", p, at);
        end
        rd(5);
        checks++;
        if (rd_len !== 8'd5) begin errors++; $display("FAIL rd5 got %0d expected 5", rd_len); end
        rd(300);
        checks++;
        if (rd_len !== 8'd44) begin errors++; $display("FAIL rd300 got %0d expected 44", rd_len); end
    endtask

    task automatic test_frame2();
        int p, at;
        stream(DEPTH, 1);
        rd(5);
        checks++;
        if (rd_len !== 8'd5) begin errors++; $display("FAIL rd5_preswap got %0d expected 5", rd_len); end
        swap_vs(p, at);
        checks++;
        if (p != 1) begin errors++; $display("FAIL frame2_pulse count=%0d expected 1", p); end
        rd(5);
        checks++;
        if (rd_len !== 8'd250) begin errors++; $display("FAIL rd5_frame2 got %0d expected 250", rd_len); end
        rd(600);
        checks++;
        if (rd_len !== 8'd0) begin errors++; $display("FAIL rd600 got %0d expected 0", rd_len); end
        rd(256);
        checks++;
        if (rd_len !== 8'd255) begin errors++; $display("FAIL rd256 got %0d expected 255", rd_len); end
        sweep();
    endtask

    task automatic test_partial_clear();
        int p, at;
        stream(100, 2);
        swap_vs(p, at);
        checks++;
        if (p != 0 || fill_level !== 11'd100) begin
            errors++;
            $display("FAIL partial_vsync pulses=%0d fill=%0d expected 0 and 100", p, fill_level);
        end
        cyc(1'b1, 8'hAA, 1'b1, VS_IDLE, '0);
        checks++;
        if (fill_level !== 11'd0) begin
            errors++;
            $display("FAIL clear_fill got %0d expected 0", fill_level);
        end
        stream(DEPTH, 2);
        swap_vs(p, at);
        checks++;
        if (p != 1) begin errors++; $display("FAIL refill_pulse count=%0d expected 1", p); end
        rd(100);
        checks++;
        if (rd_len !== 8'd44) begin errors++; $display("FAIL rd100_refill got %0d expected 44", rd_len); end
        rd(7);
        checks++;
        if (rd_len !== 8'd21) begin errors++; $display("FAIL rd7_refill got %0d expected 21", rd_len); end
        sweep();
    endtask

    task automatic test_back_to_back();
        int p, at, guard, fd;
        for (int f = 0; f < 2; f++) begin
            n_acc = 0; guard = 0;
            while (m_ptr < DEPTH - 1 && guard < 20000) begin
                cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'b0, VS_IDLE, AW'($urandom_range(0, 700)));
                guard++;
            end
            checks++;
            if (guard >= 20000) begin errors++; $display("FAIL random_fill_timeout frame=%0d", f); end
            // last accept coincides with the vsync edge
            cyc(1'b1, 8'($urandom), 1'b0, VS_ACT, '0);
            fd = 0;
            for (int k = 0; k < 6; k++) begin
                cyc(1'b1, 8'($urandom), 1'b0, VS_ACT, AW'($urandom_range(0, 700)));
                if (frame_done === 1'b1) fd++;
            end
            checks++;
            if (fd != 0 || n_acc != DEPTH || fill_level !== 11'd512) begin
                errors++;
                $display("FAIL random_frame%0d pulses=%0d accepts=%0d fill=%0d expected 0/512/512",
                         f, fd, n_acc, fill_level);
            end
            cyc(1'b0, 8'h00, 1'b0, VS_IDLE, '0);
            swap_vs(p, at);
            checks++;
            if (p != 1) begin errors++; $display("FAIL random_swap%0d count=%0d expected 1", f, p); end
            sweep();
        end
    endtask

    task automatic test_reset_mid();
        int p, at;
        stream(DEPTH, 0);
        s_valid = 1'b0; clear = 1'b0; vsync = VS_IDLE; rd_addr = '0;
        rst_n = 1'b0;
        #1;
        m_reset();
        checks++;
        if (rd_len !== 8'h00 || frame_done !== 1'b0 || fill_level !== '0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state rd_len=%0d frame_done=%0b fill=%0d s_ready=%0b expected 0/0/0/0",
                     rd_len, frame_done, fill_level, s_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        m_rdy = 1'b1;
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got %0b expected 1", s_ready); end
        rd(5);
        checks++;
        if (rd_len !== 8'd0) begin errors++; $display("FAIL midreset_blank got %0d expected 0", rd_len); end
        stream(DEPTH, 3);
        swap_vs(p, at);
        checks++;
        if (p != 1) begin errors++; $display("FAIL midreset_swap count=%0d expected 1", p); end
        rd(5);
        checks++;
        if (rd_len !== 8'h5F) begin errors++; $display("FAIL midreset_rd5 got %0d expected 95", rd_len); end
        sweep();
    endtask

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; clear = 1'b0;
        vsync = VS_IDLE; rd_addr = '0;
        m_reset();
        test_reset();
        test_frame1();
        test_frame2();
        test_partial_clear();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
